ex_mem_stage: RTL and testbench

//  EX/MEM pipeline register plus data-memory access control for the 5-stage MIPS core.

---
 rtl/ex_mem_stage.sv | 138 +++++++++++++
 tb/tb_ex_mem_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with multi-cycle data-memory req/ack control.
// Optional build macro MEM_TIMEOUT_EN adds a sticky access-timeout abort.
module ex_mem_stage #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              ValidE,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic              BranchE,
    input  logic              ZeroE,
    input  logic [DATA_W-1:0] ALUOutE,
    input  logic [DATA_W-1:0] WriteDataE,
    input  logic [DATA_W-1:0] PCBranchE,
    input  logic [DATA_W-1:0] PCplus4E,
    input  logic [4:0]        WriteRegE,
    output logic              StallM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic [4:0]        WriteRegM,
    output logic [DATA_W-1:0] ALUOutM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic [DATA_W-1:0] PCplus4M,
    output logic [DATA_W-1:0] PCBranchM,
    output logic              PCSrcM,
    output logic              MemErrM
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic              valid_m;
    logic              reg_write_l;
    logic              memto_reg_l;
    logic              mem_write_l;
    logic              branch_l;
    logic              zero_l;
    logic [DATA_W-1:0] alu_out_l;
    logic [DATA_W-1:0] wdata_l;
    logic [DATA_W-1:0] pc_branch_l;
    logic [DATA_W-1:0] pc_plus4_l;
    logic [4:0]        write_reg_l;
    logic              busy;
    logic              done;
    logic              memop;
    logic              timeout;

    assign busy  = (state == BUSY);
    assign done  = busy & dmem_ack;
    assign memop = ValidE & (MemtoRegE | MemWriteE);

    assign StallM     = busy & ~dmem_ack;
    assign dmem_req   = busy;
    assign dmem_we    = busy & mem_write_l;
    assign dmem_addr  = alu_out_l;
    assign dmem_wdata = wdata_l;

    assign ReadDataM = (done & memto_reg_l & ~mem_write_l) ? dmem_rdata : '0;
    // Held instructions present as bubbles so MEM/WB never writes twice
    assign RegWriteM = reg_write_l & valid_m & ~StallM;
    assign PCSrcM    = branch_l & zero_l & valid_m & ~StallM;
    assign MemtoRegM = memto_reg_l;
    assign WriteRegM = write_reg_l;
    assign ALUOutM   = alu_out_l;
    assign PCplus4M  = pc_plus4_l;
    assign PCBranchM = pc_branch_l;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] tmo_cnt;
    logic          mem_err;

    assign timeout = StallM & (tmo_cnt == TMO_LAST);
    assign MemErrM = mem_err;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            tmo_cnt <= '0;
            mem_err <= 1'b0;
        end else if (!StallM) begin
            tmo_cnt <= '0;
        end else if (timeout) begin
            mem_err <= 1'b1;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign MemErrM = 1'b0;
`endif

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state       <= IDLE;
            valid_m     <= 1'b0;
            reg_write_l <= 1'b0;
            memto_reg_l <= 1'b0;
            mem_write_l <= 1'b0;
            branch_l    <= 1'b0;
            zero_l      <= 1'b0;
            alu_out_l   <= '0;
            wdata_l     <= '0;
            pc_branch_l <= '0;
            pc_plus4_l  <= '0;
            write_reg_l <= '0;
        end else if (!StallM) begin
            state       <= memop ? BUSY : IDLE;
            valid_m     <= ValidE;
            reg_write_l <= RegWriteE;
            memto_reg_l <= MemtoRegE;
            mem_write_l <= MemWriteE;
            branch_l    <= BranchE;
            zero_l      <= ZeroE;
            alu_out_l   <= ALUOutE;
            wdata_l     <= WriteDataE;
            pc_branch_l <= PCBranchE;
            pc_plus4_l  <= PCplus4E;
            write_reg_l <= WriteRegE;
        end else if (timeout) begin
            // Abandoned access: drop the instruction, release next cycle
            state   <= IDLE;
            valid_m <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: write-back and memory-request queues.
// Timeout checks are compiled in when MEM_TIMEOUT_EN is defined.
module tb_ex_mem_stage;

    typedef struct {
        bit          v, rw, mtr, mw, br, z;
        logic [31:0] alu, wd, pcb, pc4, rd;
        logic [4:0]  wr;
        int          lat;
    } ins_t;

    typedef struct {
        logic        we;
        logic [31:0] addr, wdata, rd;
        int          lat;
    } mexp_t;

    typedef struct {
        logic [4:0]  wr;
        logic [31:0] alu, rd, pcb, pc4;
        logic        rw, pcsrc, mtr;
    } wexp_t;

    logic        clk = 0;
    logic        RESET_N = 0;
    logic        ValidE = 0, RegWriteE = 0, MemtoRegE = 0, MemWriteE = 0;
    logic        BranchE = 0, ZeroE = 0;
    logic [31:0] ALUOutE = 0, WriteDataE = 0, PCBranchE = 0, PCplus4E = 0;
    logic [4:0]  WriteRegE = 0;
    logic        StallM, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = 0;
    logic        dmem_ack = 0;
    logic        RegWriteM, MemtoRegM, PCSrcM, MemErrM;
    logic [4:0]  WriteRegM;
    logic [31:0] ALUOutM, ReadDataM, PCplus4M, PCBranchM;

    int n_tests = 0, n_fail = 0;
    int stall_cnt = 0, req_cnt = 0;
    bit stray = 0;
    mexp_t mq[$];
    wexp_t wq[$];

    ex_mem_stage dut (
        .CLOCK(clk), .RESET_N(RESET_N), .ValidE(ValidE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .ZeroE(ZeroE), .ALUOutE(ALUOutE),
        .WriteDataE(WriteDataE), .PCBranchE(PCBranchE), .PCplus4E(PCplus4E),
        .WriteRegE(WriteRegE), .StallM(StallM), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
        .ReadDataM(ReadDataM), .PCplus4M(PCplus4M), .PCBranchM(PCBranchM),
        .PCSrcM(PCSrcM), .MemErrM(MemErrM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory model: checks each request, acks after its programmed latency
    int cyc = 0;
    int cur_lat = 0;
    always @(negedge clk) begin
        dmem_ack   = 0;
        dmem_rdata = $urandom;
        if (!RESET_N) begin
            cyc = 0;
        end else if (stray) begin
            dmem_ack = 1;
        end else if (dmem_req) begin
            if (mq.size() == 0) begin
                check("unexpected_req", 1, 0);
            end else begin
                if (cyc == 0) begin
                    check("req_we", dmem_we, mq[0].we);
                    check("req_addr", dmem_addr, mq[0].addr);
                    check("req_wdata", dmem_wdata, mq[0].wdata);
                end
                cur_lat = mq[0].lat;
                cyc++;
                if (cyc == cur_lat) begin
                    dmem_ack   = 1;
                    dmem_rdata = mq[0].rd;
                    void'(mq.pop_front());
                    cyc = 0;
                end
            end
        end else begin
            cyc = 0;
        end
    end

    // Output monitor: pops write-back expectations as instructions retire
    always @(negedge clk) begin
        #1;
        if (RESET_N) begin
            if (StallM) stall_cnt++;
            if (dmem_req) req_cnt++;
            if (StallM) begin
                check("rw_stalled", RegWriteM, 0);
                check("pcsrc_stalled", PCSrcM, 0);
            end
            if (!dmem_ack) check("rdata_noack", ReadDataM, 0);
            if (!StallM && (RegWriteM || PCSrcM)) begin
                if (wq.size() == 0) begin
                    check("unexpected_wb", 1, 0);
                end else begin
                    check("wb_rw", RegWriteM, wq[0].rw);
                    check("wb_pcsrc", PCSrcM, wq[0].pcsrc);
                    check("wb_wreg", WriteRegM, wq[0].wr);
                    check("wb_alu", ALUOutM, wq[0].alu);
                    check("wb_rdata", ReadDataM, wq[0].rd);
                    check("wb_mtr", MemtoRegM, wq[0].mtr);
                    check("wb_pc4", PCplus4M, wq[0].pc4);
                    check("wb_pcb", PCBranchM, wq[0].pcb);
                    void'(wq.pop_front());
                end
            end
        end
    end

    task automatic issue(input ins_t i);
        int n;
        mexp_t m;
        wexp_t w;
        @(negedge clk);
        ValidE = i.v; RegWriteE = i.rw; MemtoRegE = i.mtr;
        MemWriteE = i.mw; BranchE = i.br; ZeroE = i.z;
        ALUOutE = i.alu; WriteDataE = i.wd; PCBranchE = i.pcb;
        PCplus4E = i.pc4; WriteRegE = i.wr;
        #2;
        n = 0;
        while (StallM && n < 200) begin
            @(negedge clk); #2; n++;
        end
        if (n >= 200) check("issue_timeout", 1, 0);
        if (i.v && (i.mtr || i.mw)) begin
            m.we = i.mw; m.addr = i.alu; m.wdata = i.wd;
            m.rd = i.rd; m.lat = i.lat;
            mq.push_back(m);
        end
        if (i.v && (i.rw || (i.br && i.z))) begin
            w.wr = i.wr; w.alu = i.alu; w.pcb = i.pcb; w.pc4 = i.pc4;
            w.rd = (i.mtr && !i.mw) ? i.rd : 32'h0;
            w.rw = i.rw; w.pcsrc = i.br && i.z; w.mtr = i.mtr;
            wq.push_back(w);
        end
        @(posedge clk);
    endtask

    function automatic ins_t mk(bit rw, bit mtr, bit mw, logic [31:0] alu,
                                logic [31:0] wd, logic [4:0] wr,
                                logic [31:0] rd, int lat);
        ins_t i;
        i.v = 1; i.rw = rw; i.mtr = mtr; i.mw = mw; i.br = 0; i.z = 0;
        i.alu = alu; i.wd = wd; i.wr = wr; i.rd = rd; i.lat = lat;
        i.pcb = $urandom; i.pc4 = $urandom;
        return i;
    endfunction

    task automatic bubble(input int n);
        ins_t b;
        b = mk(0, 0, 0, 0, 0, 0, 0, 0);
        b.v = 0;
        repeat (n) issue(b);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((wq.size() != 0 || mq.size() != 0) && n < 100) begin
            bubble(1);
            n++;
        end
        check("drain", wq.size() + mq.size(), 0);
    endtask

    initial begin
        ins_t i;
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        RESET_N = 1;
        #1;
        check("rst_stall", StallM, 0);
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_rw", RegWriteM, 0);
        check("rst_mtr", MemtoRegM, 0);
        check("rst_wreg", WriteRegM, 0);
        check("rst_alu", ALUOutM, 0);
        check("rst_rd", ReadDataM, 0);
        check("rst_pc4", PCplus4M, 0);
        check("rst_pcb", PCBranchM, 0);
        check("rst_pcsrc", PCSrcM, 0);
        check("rst_err", MemErrM, 0);

        stall_cnt = 0;
        issue(mk(1, 0, 0, 32'h10, 0, 5, 0, 0));
        bubble(2);
        check("alu_stall", stall_cnt, 0);
        check("alu_drain", wq.size(), 0);

        stall_cnt = 0; req_cnt = 0;
        issue(mk(1, 1, 0, 32'h40, 0, 7, 32'hDEADBEEF, 3));
        bubble(1);
        drain();
        check("ld3_stall", stall_cnt, 2);
        check("ld3_req", req_cnt, 3);

        stall_cnt = 0; req_cnt = 0;
        issue(mk(0, 0, 1, 32'h80, 32'h1234, 0, 0, 1));
        bubble(2);
        check("st_stall", stall_cnt, 0);
        check("st_req", req_cnt, 1);

        stall_cnt = 0; req_cnt = 0;
        issue(mk(1, 1, 0, 32'h100, 0, 9, 32'hAAAA5555, 1));
        issue(mk(1, 1, 0, 32'h104, 0, 10, 32'h12345678, 1));
        bubble(2);
        check("b2b_stall", stall_cnt, 0);
        check("b2b_req", req_cnt, 2);

        i = mk(0, 0, 0, 32'h3, 0, 0, 0, 0);
        i.br = 1; i.z = 1; i.pcb = 32'h200;
        issue(i);
        i.z = 0;
        issue(i);
        bubble(2);
        check("br_drain", wq.size(), 0);

        stall_cnt = 0;
        issue(mk(1, 1, 0, 32'h44, 0, 3, 32'hCAFEF00D, 6));
        bubble(1);
        drain();
        check("ld6_stall", stall_cnt, 5);

        for (k = 0; k < 16; k++) begin
            case ($urandom_range(0, 2))
                0: issue(mk(1, 0, 0, $urandom, 0, 5'($urandom), 0, 0));
                1: issue(mk(1, 1, 0, $urandom, 0, 5'($urandom), $urandom,
                            $urandom_range(1, 4)));
                default: issue(mk(0, 0, 1, $urandom, $urandom, 0, 0,
                                  $urandom_range(1, 4)));
            endcase
        end
        drain();

        issue(mk(0, 1, 0, 32'h60, 0, 4, 32'h5A5A, 0));
        @(negedge clk);
        ValidE = 0;
        repeat (2) @(negedge clk);
        RESET_N = 0;
        @(negedge clk);
        RESET_N = 1;
        mq.delete();
        wq.delete();
        #1;
        check("rstbusy_req", dmem_req, 0);
        check("rstbusy_rw", RegWriteM, 0);
        stray = 1;
        repeat (2) begin
            @(negedge clk); #2;
            check("late_ack_req", dmem_req, 0);
            check("late_ack_rw", RegWriteM, 0);
            check("late_ack_stall", StallM, 0);
            check("late_ack_rd", ReadDataM, 0);
        end
        stray = 0;

`ifdef MEM_TIMEOUT_EN
        stall_cnt = 0;
        issue(mk(0, 1, 0, 32'h70, 0, 6, 0, 0));
        @(negedge clk);
        ValidE = 0;
        repeat (22) @(negedge clk);
        #2;
        check("tmo_stall", stall_cnt, 16);
        check("tmo_err", MemErrM, 1);
        check("tmo_req", dmem_req, 0);
        mq.delete();
`else
        check("no_err", MemErrM, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        check("global_timeout", 1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "global timeout");
    end

endmodule
